// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths, FSM encodings and command layout for the I2C command sequencer
package i2c_pkg;

  localparam int I2C_DATA_WIDTH = 8;
  localparam int I2C_REG_WIDTH  = 8;
  localparam int I2C_ADDR_WIDTH = 7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_LAUNCH    = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;
  localparam state_t ST_RESP      = 2'd3;

  typedef struct packed {
    logic                      rw;
    logic [I2C_ADDR_WIDTH-1:0] device_addr;
    logic [I2C_REG_WIDTH-1:0]  reg_addr;
    logic [I2C_DATA_WIDTH-1:0] data;
  } i2c_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// rtl/i2c_cmd_fifo.sv - synchronous command FIFO, power-of-two depth, registered level
module i2c_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues I2C register commands, drives the master enable/busy handshake, returns one response per command
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH    = I2C_DATA_WIDTH,
  parameter int REG_WIDTH     = I2C_REG_WIDTH,
  parameter int ADDR_WIDTH    = I2C_ADDR_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT  = 1 << 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rw,
  input  logic [ADDR_WIDTH-1:0] i_cmd_device_addr,
  input  logic [REG_WIDTH-1:0]  i_cmd_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  input  logic [15:0]           i_divider,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_rw,
  output logic                  o_rsp_error,
  output logic                  o_enable,
  output logic                  o_rw,
  output logic [DATA_WIDTH-1:0] o_mosi_data,
  output logic [REG_WIDTH-1:0]  o_reg_addr,
  output logic [ADDR_WIDTH-1:0] o_device_addr,
  output logic [15:0]           o_divider,
  input  logic [DATA_WIDTH-1:0] i_miso_data,
  input  logic                  i_busy
);

  localparam int CMD_W   = 1 + ADDR_WIDTH + REG_WIDTH + DATA_WIDTH;
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_MAX = max_int(START_TIMEOUT, BUSY_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  enable_q, enable_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] dev_q, dev_d;
  logic [REG_WIDTH-1:0]  reg_q, reg_d;
  logic [DATA_WIDTH-1:0] mosi_q, mosi_d;
  logic [15:0]           div_q, div_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_rw_q, rsp_rw_d;
  logic                  rsp_error_q, rsp_error_d;

  logic                  cmd_push, dispatch;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_level, level_nxt;
  logic [CMD_W-1:0]      head;

  assign cmd_push = i_cmd_valid && cmd_ready_q && !fifo_full;

  i2c_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (cmd_push),
    .i_data  ({i_cmd_rw, i_cmd_device_addr, i_cmd_reg_addr, i_cmd_data}),
    .i_pop   (dispatch),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  assign level_nxt = fifo_level + LVL_W'(cmd_push) - LVL_W'(dispatch);
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enable_d    = enable_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    mosi_d      = mosi_q;
    div_d       = div_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_error_d = rsp_error_q;
    dispatch    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A master still busy after a timeout holds off the next command.
        if (!fifo_empty && !rsp_valid_q && !i_busy) begin
          dispatch = 1'b1;
          rw_d     = head[CMD_W-1];
          dev_d    = head[CMD_W-2 -: ADDR_WIDTH];
          reg_d    = head[DATA_WIDTH+REG_WIDTH-1 -: REG_WIDTH];
          mosi_d   = head[DATA_WIDTH-1:0];
          div_d    = i_divider;
          cnt_d    = '0;
          enable_d = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (i_busy) begin
          enable_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WAIT_DONE;
        end else if (cnt_q == START_LAST) begin
          enable_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
          rsp_rw_d    = rw_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_busy) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_data_d  = rw_q ? i_miso_data : '0;
          rsp_rw_d    = rw_q;
          state_d     = ST_RESP;
        end else if (cnt_q == BUSY_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
          rsp_rw_d    = rw_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (level_nxt != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      enable_q    <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      mosi_q      <= '0;
      div_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rw_q    <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      enable_q    <= enable_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      mosi_q      <= mosi_d;
      div_q       <= div_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_enable      = enable_q;
  assign o_rw          = rw_q;
  assign o_device_addr = dev_q;
  assign o_reg_addr    = reg_q;
  assign o_mosi_data   = mosi_q;
  assign o_divider     = div_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_rw      = rsp_rw_q;
  assign o_rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - directed self-checking bench for i2c_cmd_sequencer with a behavioural master model
module tb_i2c_cmd_sequencer;
  import i2c_pkg::*;

  localparam int DW = 8, RW = 8, AW = 7;
  localparam int ST = 16, BT = 100, BUSY_LEN = 5;
  localparam int M_NORMAL = 0, M_DEAD = 1, M_STUCK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_rw;
  logic [AW-1:0] cmd_dev;
  logic [RW-1:0] cmd_reg;
  logic [DW-1:0] cmd_data;
  logic [15:0]   divider;
  logic          rsp_valid, rsp_ready, rsp_rw, rsp_error;
  logic [DW-1:0] rsp_data;
  logic          m_enable, m_rw, busy;
  logic [DW-1:0] m_mosi, miso;
  logic [RW-1:0] m_reg;
  logic [AW-1:0] m_dev;
  logic [15:0]   m_div;

  i2c_cmd_sequencer #(
    .DATA_WIDTH(DW), .REG_WIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4),
    .START_TIMEOUT(ST), .BUSY_TIMEOUT(BT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
    .i_cmd_device_addr(cmd_dev), .i_cmd_reg_addr(cmd_reg), .i_cmd_data(cmd_data),
    .i_divider(divider),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_rw(rsp_rw), .o_rsp_error(rsp_error),
    .o_enable(m_enable), .o_rw(m_rw), .o_mosi_data(m_mosi), .o_reg_addr(m_reg),
    .o_device_addr(m_dev), .o_divider(m_div),
    .i_miso_data(miso), .i_busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: busy rises the cycle after enable and lasts BUSY_LEN cycles.
  int mode = M_NORMAL;
  int busy_left = 0;
  logic [DW-1:0] mem [256];
  initial begin
    busy = 1'b0;
    miso = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (mode == M_DEAD) begin
        busy = 1'b0;
      end else if (busy) begin
        if (mode == M_NORMAL) begin
          if (busy_left <= 1) begin busy = 1'b0; busy_left = 0; end
          else busy_left--;
        end
      end else if (m_enable) begin
        busy = 1'b1;
        busy_left = BUSY_LEN;
        if (m_rw) miso = mem[m_reg];
        else mem[m_reg] = m_mosi;
      end
    end
  end

  int cyc = 0, en_rises = 0, en_high = 0, en_fall_cyc = 0, rsp_rise_cyc = 0;
  logic en_prev = 1'b0, rv_prev = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (m_enable) en_high++;
      if (m_enable && !en_prev) en_rises++;
      if (!m_enable && en_prev) en_fall_cyc = cyc;
      if (rsp_valid && !rv_prev) rsp_rise_cyc = cyc;
      en_prev = m_enable;
      rv_prev = rsp_valid;
    end
  end

  task automatic send(input logic rw, input logic [AW-1:0] dev, input logic [RW-1:0] ra, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = ra; cmd_data = d;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    check("send_ready", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin @(negedge clk); n++; end
    check(tag, rsp_valid, 1);
  endtask

  task automatic expect_rsp(input string tag, input logic erw, input logic [DW-1:0] ed, input logic eerr);
    wait_rsp({tag, "_arrive"}, 400);
    check(tag, {rsp_rw, rsp_data, rsp_error}, {erw, ed, eerr});
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int r0, h0, acc, unstable, n;
  i2c_cmd_t tbl [5];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_data = '0;
    rsp_ready = 1'b0; divider = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_enable", m_enable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_master_ports", {m_rw, m_dev, m_reg, m_mosi, m_div}, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Write then read back through the master model.
    send(1'b0, 7'h11, 8'h00, 8'hDC);
    check("lat_enable_early", m_enable, 0);
    send(1'b1, 7'h11, 8'h00, 8'h00);
    check("lat_enable", m_enable, 1);
    check("master_ports", {m_rw, m_dev, m_reg, m_mosi, m_div}, {1'b0, 7'h11, 8'h00, 8'hDC, 16'hFFFF});
    expect_rsp("wr_rsp", 1'b0, 8'h00, 1'b0);
    expect_rsp("rd_rsp", 1'b1, 8'hDC, 1'b0);

    // FIFO full while the master never answers and responses are held off.
    mode = M_DEAD;
    @(negedge clk);
    r0 = en_rises; h0 = en_high; acc = 0;
    for (int i = 0; i < 5; i++) tbl[i] = '{rw: i[0], device_addr: 7'h22, reg_addr: 8'h10 + 8'(i), data: 8'(i)};
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_rw = i[0]; cmd_dev = 7'h22; cmd_reg = 8'h10 + 8'(i); cmd_data = 8'(i);
      if (cmd_ready) acc++;
      @(posedge clk); @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("full_accepted", acc, 5);
    check("full_ready_low", cmd_ready, 0);
    wait_rsp("start_to_arrive", 100);
    check("start_to_enable_cycles", en_high - h0, ST);
    check("start_to_rsp", {rsp_rw, rsp_data, rsp_error}, {1'b0, 8'h00, 1'b1});
    repeat (20) @(negedge clk);
    check("full_one_launch", en_rises - r0, 1);
    check("full_ready_still_low", cmd_ready, 0);
    for (int i = 0; i < 5; i++) expect_rsp("full_drain", tbl[i].rw, 8'h00, 1'b1);

    // Busy timeout with the master stuck; the next command must wait for release.
    mode = M_STUCK;
    @(negedge clk);
    send(1'b1, 7'h11, 8'h00, 8'h00);
    send(1'b0, 7'h11, 8'h05, 8'h3C);
    wait_rsp("busy_to_arrive", 300);
    check("busy_to_cycles", rsp_rise_cyc - en_fall_cyc, BT);
    r0 = en_rises;
    expect_rsp("busy_to_rsp", 1'b1, 8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("stuck_no_dispatch", en_rises - r0, 0);
    mode = M_NORMAL;
    expect_rsp("after_release", 1'b0, 8'h00, 1'b0);
    check("after_release_launch", en_rises - r0, 1);

    // Response backpressure on a read.
    send(1'b1, 7'h11, 8'h05, 8'h00);
    send(1'b0, 7'h11, 8'h06, 8'h77);
    wait_rsp("bp_arrive", 100);
    check("bp_rsp", {rsp_rw, rsp_data, rsp_error}, {1'b1, 8'h3C, 1'b0});
    r0 = en_rises; unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 8'h3C || !rsp_rw || rsp_error) unstable++;
    end
    check("bp_stable", unstable, 0);
    check("bp_no_launch", en_rises - r0, 0);
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_enable_early", m_enable, 0);
    @(negedge clk);
    check("bp_next_launch", m_enable, 1);
    expect_rsp("bp_next_rsp", 1'b0, 8'h00, 1'b0);

    // Reset while the master is busy with queued commands behind it.
    send(1'b1, 7'h11, 8'h06, 8'h00);
    send(1'b0, 7'h11, 8'h07, 8'h01);
    send(1'b0, 7'h11, 8'h08, 8'h02);
    n = 0;
    while (!(busy && !m_enable && !rsp_valid) && n < 50) begin @(negedge clk); n++; end
    check("rst_mid_in_wait", busy && !m_enable && !rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_mid_enable", m_enable, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mid_ready_back", cmd_ready, 1);
    r0 = en_rises;
    repeat (30) @(negedge clk);
    check("rst_mid_fifo_empty", en_rises - r0, 0);
    check("rst_mid_no_rsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Command front-end that sits directly upstream of i2c_master and performs the enable/busy handshake with it. It accepts I2C register-access commands over a valid/ready stream and buffers them in a small FIFO. Each command is issued to the master, the master's busy cycle is tracked, and one response (read data or error) per command is returned on a valid/ready stream. Host logic no longer has to poll busy by hand.

Parameters:
DATA_WIDTH, 8, width of mosi/miso data; must match i2c_master.
REG_WIDTH, 8, width of the register address.
ADDR_WIDTH, 7, width of the device address.
FIFO_DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.
START_TIMEOUT, 16, maximum cycles in LAUNCH waiting for i_busy to rise.
BUSY_TIMEOUT, 2^24, maximum cycles in WAIT_DONE waiting for i_busy to fall.

Ports:
i_clk  in  1  single clock, rising edge.
i_rst  in  1  synchronous, active-high reset.
i_cmd_valid  in  1  command valid.
o_cmd_ready  out  1  high when the FIFO is not full.
i_cmd_rw  in  1  0 = write, 1 = read.
i_cmd_device_addr  in  ADDR_WIDTH  slave address.
i_cmd_reg_addr  in  REG_WIDTH  register address.
i_cmd_data  in  DATA_WIDTH  write data; ignored on reads.
i_divider  in  16  SCL divider, sampled at launch.
o_rsp_valid  out  1  response valid.
i_rsp_ready  in  1  response accepted.
o_rsp_data  out  DATA_WIDTH  read data; 0 for writes and for errors.
o_rsp_rw  out  1  echo of the command's rw.
o_rsp_error  out  1  a timeout occurred.
o_enable, o_rw, o_mosi_data, o_reg_addr, o_device_addr, o_divider  out  1/1/DATA_WIDTH/REG_WIDTH/ADDR_WIDTH/16  connect to the master's i_enable, i_rw, i_mosi_data, i_reg_addr, i_device_addr, i_divider.
i_miso_data  in  DATA_WIDTH  from master o_miso_data.
i_busy  in  1  from master o_busy.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - FIFO empties; state goes to IDLE; timeout counter clears.
  - Every output register goes to 0, including o_cmd_ready, o_enable and o_rsp_valid.
  - o_cmd_ready is 1 on the first cycle after reset deasserts.
- Reset mid-operation: o_enable drops on the next edge. Queued commands and any pending response are discarded.
- FIFO:
  - Push on i_cmd_valid & o_cmd_ready; pop when IDLE dispatches.
  - Simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
  - o_cmd_ready is registered and equals (level != FIFO_DEPTH).
- State machine, one state per cycle minimum:
  - IDLE: dispatch when FIFO not empty, !o_rsp_valid and !i_busy. Dispatch pops the head, registers it onto the o_* master ports, samples i_divider into o_divider, clears the counter and goes to LAUNCH.
  - LAUNCH:
    - o_enable=1.
    - On i_busy=1: o_enable=0 and go to WAIT_DONE.
    - If the counter reaches START_TIMEOUT first: o_enable=0, o_rsp_error=1, go to RESP.
  - WAIT_DONE:
    - On i_busy=0: o_rsp_data = i_miso_data if rw=1, else 0; go to RESP.
    - If the counter reaches BUSY_TIMEOUT first: error response, go to RESP.
  - RESP: o_rsp_valid=1, with data/rw/error held stable until i_rsp_ready. On the handshake cycle clear o_rsp_valid and go to IDLE.
- Latency: with the master ready, o_enable rises 1 cycle after dispatch, i.e. 2 cycles after the push into an empty FIFO. o_rsp_valid rises 1 cycle after the cycle in which i_busy is seen low in WAIT_DONE.
- o_enable is never high outside LAUNCH. Master ports hold the last command's values between commands.
- The timeout counter is sized to clog2(max(START_TIMEOUT, BUSY_TIMEOUT)+1) bits and saturates; it never wraps.
- After a busy timeout, IDLE blocks dispatch until i_busy=0, so a stuck master stalls the sequencer without corrupting later commands.
- Commands are completed strictly in order; exactly one response per accepted command.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT_DONE, RESP);
  - the command struct {rw, device_addr, reg_addr, data};
  - default widths shared with i2c_master.
- One sub-module, i2c_cmd_fifo: synchronous FIFO, parameterised width/depth, with push/pop/full/empty/level.
- The FSM stays in the top module.

Test Plan:
- Write then read through i2c_master and i2c_slave: push write (dev 0x11, reg 0x00, data 0xDC, divider 0xFFFF), then push read (same dev/reg). Expect two responses in order: {rw=0, data=0x00, err=0} then {rw=1, data=0xDC, err=0}.
- FIFO full with i_rsp_ready=0 and i_cmd_valid held high for 6 cycles: 5 commands accepted (4 in FIFO, 1 popped to the master). o_cmd_ready=0 afterwards; only 1 o_enable pulse until the response is accepted.
- Start timeout, i_busy tied 0, START_TIMEOUT=16: o_enable stays high exactly 16 cycles, then o_rsp_valid=1 with err=1, data=0.
- Busy timeout, BUSY_TIMEOUT=100, i_busy tied 1 after the launch: error response after 100 cycles. The next queued command is not dispatched until i_busy is released, then completes normally.
- Response backpressure: hold i_rsp_ready=0 for 50 cycles after a read. o_rsp_valid/o_rsp_data stay stable, with no new o_enable; after release, the next command launches 1 cycle later.
- Reset mid-transfer: assert i_rst in WAIT_DONE. Next cycle o_enable=0, o_rsp_valid=0, o_cmd_ready=0; one cycle after release o_cmd_ready=1 and the FIFO is empty.
